// File: rtl/sample_scheduler.sv
// sample_scheduler: per-iteration index sampling, dedup/range filtering and issue to the spin update engine.
module sample_scheduler #(
    parameter int SAMPLE        = 4,
    parameter int ITER_WIDTH    = 16,
    parameter int ADDR_BITWIDTH = 8,
    parameter int NUM_SPINS     = 200
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [ITER_WIDTH-1:0]                num_iters,
    output logic                                 gen_ena,
    input  logic [SAMPLE-1:0][ADDR_BITWIDTH-1:0] gen_index,
    output logic                                 upd_valid,
    output logic [ADDR_BITWIDTH-1:0]             upd_index,
    input  logic                                 upd_ready,
    input  logic                                 upd_done,
    output logic                                 busy,
    output logic                                 done,
    output logic [ITER_WIDTH-1:0]                iter_count,
    output logic [ITER_WIDTH-1:0]                skip_count
);
    localparam int PW = SAMPLE > 1 ? $clog2(SAMPLE) : 1;
    localparam int OW = $clog2(SAMPLE + 1);
    localparam logic [ADDR_BITWIDTH:0] LIM = (ADDR_BITWIDTH + 1)'(NUM_SPINS);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, CAPT, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [SAMPLE-1:0][ADDR_BITWIDTH-1:0] idx;
    logic [SAMPLE-1:0] kept, keep;
    logic [PW-1:0] ptr, first, nxt;
    logic [OW-1:0] outstanding, out_n;
    logic [ITER_WIDTH-1:0] limit;
    logic [ITER_WIDTH:0] skip_sum;
    logic has_next, hs, dec, armed;
    always_comb begin
        keep = '0;
        first = '0;
        nxt = '0;
        has_next = 1'b0;
        for (int i = 0; i < SAMPLE; i++) begin
            keep[i] = {1'b0, gen_index[i]} < LIM;
            for (int j = 0; j < i; j++)
                if (keep[j] && gen_index[j] == gen_index[i]) keep[i] = 1'b0;
        end
        for (int i = SAMPLE - 1; i >= 0; i--) begin
            if (keep[i]) first = PW'(i);
            if (kept[i] && i > int'(ptr)) begin
                nxt = PW'(i);
                has_next = 1'b1;
            end
        end
        hs = upd_valid & upd_ready;
        // a completion arriving with nothing outstanding is only honoured if it pairs with a handshake
        dec = upd_done & (outstanding != '0 | hs);
        out_n = outstanding + OW'(hs) - OW'(dec);
        skip_sum = {1'b0, skip_count} + (ITER_WIDTH + 1)'(SAMPLE - $countones(keep));
        armed = (state == IDLE || state == DONE) && start;
        state_n = state;
        if (abort) state_n = IDLE;
        else case (state)
            IDLE, DONE: if (start) state_n = num_iters == '0 ? DONE : REQ;
            REQ:        state_n = WAIT;
            WAIT:       state_n = CAPT;
            CAPT:       state_n = keep != '0 ? ISSUE : DRAIN;
            ISSUE:      if (hs && !has_next) state_n = DRAIN;
            DRAIN:      if (out_n == '0) state_n = iter_count + 1'b1 == limit ? DONE : REQ;
            default:    state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            gen_ena     <= 1'b0;
            upd_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            upd_index   <= '0;
            iter_count  <= '0;
            skip_count  <= '0;
            outstanding <= '0;
            limit       <= '0;
            idx         <= '0;
            kept        <= '0;
            ptr         <= '0;
        end else begin
            state       <= state_n;
            gen_ena     <= state_n == REQ;
            upd_valid   <= state_n == ISSUE;
            busy        <= state_n != IDLE && state_n != DONE;
            done        <= state_n == DONE;
            outstanding <= abort ? '0 : out_n;
            if (!abort) begin
                if (armed) begin
                    limit      <= num_iters;
                    iter_count <= '0;
                    skip_count <= '0;
                end
                if (state == CAPT) begin
                    idx        <= gen_index;
                    kept       <= keep;
                    ptr        <= first;
                    upd_index  <= gen_index[first];
                    skip_count <= skip_sum[ITER_WIDTH] ? '1 : skip_sum[ITER_WIDTH-1:0];
                end
                if (hs && has_next) begin
                    ptr       <= nxt;
                    upd_index <= idx[nxt];
                end
                if (state == DRAIN && out_n == '0) iter_count <= iter_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sample_scheduler.sv
// tb_sample_scheduler: scenario tasks with a scoreboard of expected issued indices.
module tb_sample_scheduler;
    localparam int SAMPLE = 4;
    localparam int IW = 16;
    localparam int AW = 8;
    localparam int NS = 200;
    logic clk = 0, reset = 1, start = 0, abort = 0, upd_ready = 0, upd_done = 0;
    logic [IW-1:0] num_iters = '0;
    logic [SAMPLE-1:0][AW-1:0] gen_index = '0;
    logic gen_ena, upd_valid, busy, done;
    logic [AW-1:0] upd_index;
    logic [IW-1:0] iter_count, skip_count;
    int pass_cnt = 0, total = 0, gen_cnt = 0, hs_cnt = 0;
    int exp_q[$];
    int e;

    sample_scheduler #(.SAMPLE(SAMPLE), .ITER_WIDTH(IW), .ADDR_BITWIDTH(AW), .NUM_SPINS(NS)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .num_iters(num_iters),
        .gen_ena(gen_ena), .gen_index(gen_index), .upd_valid(upd_valid), .upd_index(upd_index),
        .upd_ready(upd_ready), .upd_done(upd_done), .busy(busy), .done(done),
        .iter_count(iter_count), .skip_count(skip_count)
    );

    always #5 clk = ~clk;

    // scoreboard: every handshake the next posedge will perform is compared here
    always @(negedge clk) begin
        if (gen_ena) gen_cnt++;
        if (upd_valid && upd_ready) begin
            hs_cnt++;
            total++;
            if (exp_q.size() == 0) $display("FAIL issue_order: got index %0d, expected no issue", upd_index);
            else begin
                e = exp_q.pop_front();
                if (upd_index !== AW'(e)) $display("FAIL issue_order: got index %0d, expected %0d", upd_index, e);
                else pass_cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_gen(input int a, input int b, input int c, input int d);
        gen_index[0] = AW'(a);
        gen_index[1] = AW'(b);
        gen_index[2] = AW'(c);
        gen_index[3] = AW'(d);
    endtask

    // lat = posedges between the start-sampling edge and done being visible; -1 on timeout
    task automatic start_and_wait(input logic [IW-1:0] n, output int lat);
        num_iters = n;
        start = 1;
        tick;
        start = 0;
        lat = 0;
        while (lat < 400) begin
            @(negedge clk);
            if (done) break;
            tick;
            lat++;
        end
        if (lat >= 400) lat = -1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++; if ({gen_ena, upd_valid, busy, done} !== 4'b0) $display("FAIL reset_flags: got %b, expected 0000", {gen_ena, upd_valid, busy, done}); else pass_cnt++;
        total++; if (upd_index !== '0) $display("FAIL reset_index: got %0d, expected 0", upd_index); else pass_cnt++;
        total++; if (iter_count !== '0) $display("FAIL reset_iter: got %0d, expected 0", iter_count); else pass_cnt++;
        total++; if (skip_count !== '0) $display("FAIL reset_skip: got %0d, expected 0", skip_count); else pass_cnt++;
        @(posedge clk);
        #1 reset = 0;
        tick;
    endtask

    task automatic test_basic;
        int lat, g0;
        g0 = gen_cnt;
        set_gen(5, 9, 2, 7);
        upd_ready = 1;
        upd_done = 1;
        exp_q.push_back(5); exp_q.push_back(9); exp_q.push_back(2); exp_q.push_back(7);
        start_and_wait(1, lat);
        total++; if (lat !== 8) $display("FAIL basic_latency: got %0d, expected 8", lat); else pass_cnt++;
        total++; if (iter_count !== 16'd1) $display("FAIL basic_iter: got %0d, expected 1", iter_count); else pass_cnt++;
        total++; if (skip_count !== 16'd0) $display("FAIL basic_skip: got %0d, expected 0", skip_count); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy: got %b, expected 0", busy); else pass_cnt++;
        tick;
        total++; if (gen_cnt - g0 !== 1) $display("FAIL basic_gen: got %0d pulses, expected 1", gen_cnt - g0); else pass_cnt++;
        total++; if (exp_q.size() !== 0) $display("FAIL basic_queue: got %0d pending, expected 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_duplicates;
        int lat;
        set_gen(3, 3, 8, 3);
        exp_q.push_back(3); exp_q.push_back(8);
        start_and_wait(1, lat);
        total++; if (lat !== 6) $display("FAIL dup_latency: got %0d, expected 6", lat); else pass_cnt++;
        total++; if (skip_count !== 16'd2) $display("FAIL dup_skip: got %0d, expected 2", skip_count); else pass_cnt++;
        tick;
        total++; if (exp_q.size() !== 0) $display("FAIL dup_queue: got %0d pending, expected 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_out_of_range;
        int lat;
        set_gen(NS, NS + 1, 0, 0);
        exp_q.push_back(0);
        start_and_wait(1, lat);
        total++; if (lat !== 5) $display("FAIL range_latency: got %0d, expected 5", lat); else pass_cnt++;
        total++; if (skip_count !== 16'd3) $display("FAIL range_skip: got %0d, expected 3", skip_count); else pass_cnt++;
        tick;
        total++; if (exp_q.size() !== 0) $display("FAIL range_queue: got %0d pending, expected 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_none_kept;
        int lat, h0;
        h0 = hs_cnt;
        set_gen(NS, 255, NS + 1, 250);
        start_and_wait(1, lat);
        total++; if (lat !== 4) $display("FAIL none_latency: got %0d, expected 4", lat); else pass_cnt++;
        total++; if (skip_count !== 16'd4) $display("FAIL none_skip: got %0d, expected 4", skip_count); else pass_cnt++;
        total++; if (hs_cnt - h0 !== 0) $display("FAIL none_issues: got %0d, expected 0", hs_cnt - h0); else pass_cnt++;
        tick;
    endtask

    task automatic test_back_to_back;
        int g0, h0;
        g0 = gen_cnt;
        h0 = hs_cnt;
        set_gen(5, 9, 2, 7);
        repeat (3) begin
            exp_q.push_back(5); exp_q.push_back(9); exp_q.push_back(2); exp_q.push_back(7);
        end
        num_iters = 3;
        start = 1;
        tick;
        start = 0;
        repeat (5) tick;
        total++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b, expected 1", busy); else pass_cnt++;
        num_iters = 1;
        start = 1;
        tick;
        start = 0;
        for (int k = 0; k < 100 && !done; k++) @(negedge clk);
        total++; if (done !== 1'b1) $display("FAIL b2b_done: got %b, expected 1", done); else pass_cnt++;
        total++; if (iter_count !== 16'd3) $display("FAIL b2b_iter: got %0d, expected 3", iter_count); else pass_cnt++;
        tick;
        total++; if (hs_cnt - h0 !== 12) $display("FAIL b2b_issues: got %0d, expected 12", hs_cnt - h0); else pass_cnt++;
        total++; if (gen_cnt - g0 !== 3) $display("FAIL b2b_gen: got %0d, expected 3", gen_cnt - g0); else pass_cnt++;
    endtask

    task automatic test_backpressure;
        logic [AW-1:0] v;
        int h0;
        h0 = hs_cnt;
        upd_ready = 0;
        set_gen(5, 9, 2, 7);
        exp_q.push_back(5); exp_q.push_back(9); exp_q.push_back(2); exp_q.push_back(7);
        num_iters = 1;
        start = 1;
        tick;
        start = 0;
        for (int k = 0; k < 20 && !upd_valid; k++) @(negedge clk);
        v = upd_index;
        for (int k = 0; k < 5; k++) begin
            tick;
            @(negedge clk);
            total++; if ({upd_valid, upd_index} !== {1'b1, v}) $display("FAIL bp_stable: got valid %b index %0d, expected valid 1 index %0d", upd_valid, upd_index, v); else pass_cnt++;
        end
        upd_ready = 1;
        for (int k = 0; k < 100 && !done; k++) @(negedge clk);
        total++; if (iter_count !== 16'd1) $display("FAIL bp_iter: got %0d, expected 1", iter_count); else pass_cnt++;
        tick;
        total++; if (hs_cnt - h0 !== 4) $display("FAIL bp_issues: got %0d, expected 4", hs_cnt - h0); else pass_cnt++;
    endtask

    task automatic test_drain;
        int g0, h0;
        g0 = gen_cnt;
        h0 = hs_cnt;
        upd_done = 0;
        upd_ready = 1;
        set_gen(10, 11, 12, 13);
        repeat (2) begin
            exp_q.push_back(10); exp_q.push_back(11); exp_q.push_back(12); exp_q.push_back(13);
        end
        num_iters = 2;
        start = 1;
        tick;
        start = 0;
        for (int k = 0; k < 50 && hs_cnt < h0 + 4; k++) tick;
        total++; if (hs_cnt - h0 !== 4) $display("FAIL drain_issues: got %0d, expected 4", hs_cnt - h0); else pass_cnt++;
        repeat (10) tick;
        total++; if (gen_cnt - g0 !== 1) $display("FAIL drain_hold_gen: got %0d, expected 1", gen_cnt - g0); else pass_cnt++;
        total++; if (busy !== 1'b1) $display("FAIL drain_busy: got %b, expected 1", busy); else pass_cnt++;
        repeat (3) begin
            upd_done = 1;
            tick;
            upd_done = 0;
            tick;
        end
        total++; if (gen_cnt - g0 !== 1) $display("FAIL drain_partial_gen: got %0d, expected 1", gen_cnt - g0); else pass_cnt++;
        upd_done = 1;
        for (int k = 0; k < 100 && !done; k++) @(negedge clk);
        total++; if (iter_count !== 16'd2) $display("FAIL drain_iter: got %0d, expected 2", iter_count); else pass_cnt++;
        tick;
        total++; if (gen_cnt - g0 !== 2) $display("FAIL drain_gen: got %0d, expected 2", gen_cnt - g0); else pass_cnt++;
        total++; if (exp_q.size() !== 0) $display("FAIL drain_queue: got %0d pending, expected 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_zero_iters;
        int lat, g0;
        g0 = gen_cnt;
        start_and_wait(0, lat);
        total++; if (lat !== 0) $display("FAIL zero_latency: got %0d, expected 0", lat); else pass_cnt++;
        total++; if (iter_count !== 16'd0) $display("FAIL zero_iter: got %0d, expected 0", iter_count); else pass_cnt++;
        repeat (3) tick;
        total++; if (gen_cnt - g0 !== 0) $display("FAIL zero_gen: got %0d, expected 0", gen_cnt - g0); else pass_cnt++;
    endtask

    task automatic test_abort;
        upd_ready = 0;
        set_gen(3, 3, 8, 3);
        num_iters = 3;
        start = 1;
        tick;
        start = 0;
        for (int k = 0; k < 20 && !upd_valid; k++) @(negedge clk);
        total++; if (upd_valid !== 1'b1) $display("FAIL abort_offer: got %b, expected 1", upd_valid); else pass_cnt++;
        abort = 1;
        tick;
        abort = 0;
        total++; if ({upd_valid, busy, done} !== 3'b0) $display("FAIL abort_flags: got %b, expected 000", {upd_valid, busy, done}); else pass_cnt++;
        total++; if (skip_count !== 16'd2) $display("FAIL abort_skip: got %0d, expected 2", skip_count); else pass_cnt++;
        total++; if (iter_count !== 16'd0) $display("FAIL abort_iter: got %0d, expected 0", iter_count); else pass_cnt++;
        tick;
    endtask

    task automatic test_reset_midrun;
        int lat;
        upd_ready = 0;
        set_gen(NS, NS + 1, 0, 0);
        num_iters = 4;
        start = 1;
        tick;
        start = 0;
        for (int k = 0; k < 20 && !upd_valid; k++) @(negedge clk);
        total++; if (skip_count !== 16'd3) $display("FAIL rst_pre_skip: got %0d, expected 3", skip_count); else pass_cnt++;
        #2 reset = 1;
        #1;
        total++; if ({gen_ena, upd_valid, busy, done} !== 4'b0) $display("FAIL rst_async_flags: got %b, expected 0000", {gen_ena, upd_valid, busy, done}); else pass_cnt++;
        total++; if ({upd_index, iter_count, skip_count} !== '0) $display("FAIL rst_async_values: got %0d/%0d/%0d, expected 0/0/0", upd_index, iter_count, skip_count); else pass_cnt++;
        repeat (2) tick;
        reset = 0;
        tick;
        upd_ready = 1;
        set_gen(5, 9, 2, 7);
        exp_q.push_back(5); exp_q.push_back(9); exp_q.push_back(2); exp_q.push_back(7);
        start_and_wait(1, lat);
        total++; if (lat !== 8) $display("FAIL rst_recover_latency: got %0d, expected 8", lat); else pass_cnt++;
        tick;
        total++; if (exp_q.size() !== 0) $display("FAIL rst_recover_queue: got %0d pending, expected 0", exp_q.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_duplicates;
        test_out_of_range;
        test_none_kept;
        test_back_to_back;
        test_backpressure;
        test_drain;
        test_zero_iters;
        test_abort;
        test_reset_midrun;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
